input_sync: RTL and testbench

Conditions one raw push-button input for synchronous use. It synchronises the asynchronous pin into the clock domain, optionally inverts it (active-low buttons), and samples it only on enable strobes to give a debounced, rate-reduced level. It sits in the player-input front end: one instance per button, upstream of edge detection and one-hot encoding. All instances share a free-running enable strobe.

---
 rtl/input_sync_pkg.sv | 16 +
 rtl/input_sync_if.sv | 9 +
 rtl/input_sync_sync_ff_chain.sv | 23 ++
 rtl/input_sync.sv | 62 ++++++
 tb/tb_input_sync.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/input_sync_pkg.sv
// Shared constants and sizing helper for the button input conditioner.
package input_sync_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;
  localparam int DEBOUNCE_MIN    = 1;
  localparam int DEBOUNCE_MAX    = 15;

  // Width of a counter that must hold 0..debounce (at least one bit).
  function automatic int cnt_width(input int debounce);
    int w;
    w = $clog2(debounce + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/input_sync_if.sv
// Bundle of the per-button signals: sample strobe, raw pin, conditioned level.
interface input_sync_if;
  logic enable;
  logic signal_in;
  logic signal_out;

  modport master (output enable, output signal_in, input signal_out);
  modport slave  (input enable, input signal_in, output signal_out);
endinterface

// File: rtl/input_sync_sync_ff_chain.sv
// Single-bit multi-flop synchroniser with a configurable reset level,
// reusable for any asynchronous input.
module sync_ff_chain #(
  parameter int STAGES      = 2,
  parameter bit RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the pin through the chain every edge; bit 0 is the first capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) chain <= {STAGES{RESET_VALUE}};
    else      chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/input_sync.sv
// Push-button conditioner: synchronise, correct polarity, then debounce
// by sampling only on the shared enable strobe.
module input_sync
  import input_sync_pkg::*;
#(
  parameter bit inv         = 1'b1,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 1
) (
  input logic         clk,
  input logic         rst,
  input_sync_if.slave bus
);

  localparam int CW = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("input_sync: SYNC_STAGES out of range 2..4");
  end
  if (DEBOUNCE < DEBOUNCE_MIN || DEBOUNCE > DEBOUNCE_MAX) begin : g_bad_debounce
    $error("input_sync: DEBOUNCE out of range 1..15");
  end

  logic          sync_q;
  logic          level;
  logic          out_q;
  logic [CW-1:0] cnt;

  // Reset the chain to the idle pin level so reset release looks unpressed.
  sync_ff_chain #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (inv)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.signal_in),
    .q   (sync_q)
  );

  assign level = sync_q ^ inv;

  // Debounce: the level must disagree on DEBOUNCE consecutive strobes to flip.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      out_q <= 1'b0;
    end else if (bus.enable) begin
      if (level == out_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        out_q <= level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign bus.signal_out = out_q;

endmodule

// File: tb/tb_input_sync.sv
// Directed bench for input_sync: three instances share clock, reset and strobe
// (A: defaults, B: non-inverting, C: three-sample debounce).
module tb_input_sync;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] div;
  int         errors;
  int         checks;

  input_sync_if ifa ();
  input_sync_if ifb ();
  input_sync_if ifc ();

  assign ifa.enable = en;
  assign ifb.enable = en;
  assign ifc.enable = en;

  input_sync #(.inv(1'b1), .SYNC_STAGES(2), .DEBOUNCE(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave));
  input_sync #(.inv(1'b0), .SYNC_STAGES(2), .DEBOUNCE(1)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave));
  input_sync #(.inv(1'b1), .SYNC_STAGES(2), .DEBOUNCE(3)) dut_c (
    .clk (clk), .rst (rst), .bus (ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running strobe: high one cycle in every four, changed just after posedge.
  initial begin
    div = 2'd0;
    en  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      div = div + 2'd1;
      en  = (div == 2'd3);
    end
  end

  // Return at a negedge whose following posedge is an enabled edge (E).
  task automatic sync_to_enable();
    @(negedge clk);
    while (!en) @(negedge clk);
  endtask

  // Return at the negedge after E+1: a pin change here is first sampled at E+4.
  task automatic to_phase2();
    sync_to_enable();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ifa.signal_in = 1'b1;
    ifb.signal_in = 1'b0;
    ifc.signal_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.signal_out !== 1'b0) begin
        errors++; $display("FAIL reset_a: got %b expected 0", ifa.signal_out);
      end
      checks++;
      if (ifb.signal_out !== 1'b0) begin
        errors++; $display("FAIL reset_b: got %b expected 0", ifb.signal_out);
      end
      checks++;
      if (ifc.signal_out !== 1'b0) begin
        errors++; $display("FAIL reset_c: got %b expected 0", ifc.signal_out);
      end
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.signal_out !== 1'b0) begin
        errors++; $display("FAIL idle_a cycle %0d: got %b expected 0", i, ifa.signal_out);
      end
    end
    checks++;
    if (ifb.signal_out !== 1'b0) begin
      errors++; $display("FAIL idle_b: got %b expected 0", ifb.signal_out);
    end
    checks++;
    if (ifc.signal_out !== 1'b0) begin
      errors++; $display("FAIL idle_c: got %b expected 0", ifc.signal_out);
    end
  endtask

  task automatic test_press_release();
    // Pin falls just before enabled edge P0: sync settles after P1, next sample P4.
    sync_to_enable();
    ifa.signal_in = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.signal_out !== (k >= 5)) begin
        errors++;
        $display("FAIL press_latency k=%0d: got %b expected %b", k, ifa.signal_out, (k >= 5));
      end
    end
    repeat (5) @(negedge clk);
    // Release two cycles before a strobe: shortest path, sampled at E+4.
    to_phase2();
    ifa.signal_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (ifa.signal_out !== (k < 3)) begin
        errors++;
        $display("FAIL release_latency k=%0d: got %b expected %b", k, ifa.signal_out, (k < 3));
      end
    end
  endtask

  task automatic test_glitch();
    sync_to_enable();
    @(negedge clk);
    ifa.signal_in = 1'b0;
    @(negedge clk);
    ifa.signal_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ifa.signal_out !== 1'b0) begin
        errors++; $display("FAIL glitch_filtered cycle %0d: got %b expected 0", i, ifa.signal_out);
      end
    end
  endtask

  task automatic test_noninverted();
    checks++;
    if (ifb.signal_out !== 1'b0) begin
      errors++; $display("FAIL noninv_idle: got %b expected 0", ifb.signal_out);
    end
    to_phase2();
    ifb.signal_in = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checks++;
      if (ifb.signal_out !== (k >= 3)) begin
        errors++;
        $display("FAIL noninv_rise k=%0d: got %b expected %b", k, ifb.signal_out, (k >= 3));
      end
    end
    ifb.signal_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (ifb.signal_out !== 1'b0) begin
      errors++; $display("FAIL noninv_fall: got %b expected 0", ifb.signal_out);
    end
  endtask

  task automatic test_debounce();
    // Two pressed samples (E+4, E+8), released by E+12: must not flip.
    to_phase2();
    ifc.signal_in = 1'b0;
    repeat (8) @(negedge clk);
    ifc.signal_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (ifc.signal_out !== 1'b0) begin
        errors++; $display("FAIL debounce_short cycle %0d: got %b expected 0", i, ifc.signal_out);
      end
    end
    // Three pressed samples (E+4, E+8, E+12): flips after E+12.
    to_phase2();
    ifc.signal_in = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 3 || k == 7 || k == 10 || k == 11) begin
        checks++;
        if (ifc.signal_out !== (k >= 11)) begin
          errors++;
          $display("FAIL debounce_long k=%0d: got %b expected %b", k, ifc.signal_out, (k >= 11));
        end
      end
    end
    // Release needs three released samples as well.
    to_phase2();
    ifc.signal_in = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 7 || k == 10 || k == 11) begin
        checks++;
        if (ifc.signal_out !== (k < 11)) begin
          errors++;
          $display("FAIL debounce_release k=%0d: got %b expected %b", k, ifc.signal_out, (k < 11));
        end
      end
    end
  endtask

  task automatic test_reset_mid_press();
    to_phase2();
    ifa.signal_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (ifa.signal_out !== 1'b1) begin
      errors++; $display("FAIL pre_reset_press: got %b expected 1", ifa.signal_out);
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (ifa.signal_out !== 1'b0) begin
      errors++; $display("FAIL async_reset: got %b expected 0", ifa.signal_out);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (ifa.signal_out !== 1'b0) begin
      errors++; $display("FAIL held_reset: got %b expected 0", ifa.signal_out);
    end
    sync_to_enable();
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1 || k == 4 || k == 5) begin
        checks++;
        if (ifa.signal_out !== (k >= 5)) begin
          errors++;
          $display("FAIL post_reset_press k=%0d: got %b expected %b", k, ifa.signal_out, (k >= 5));
        end
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_press_release();
    test_glitch();
    test_noninverted();
    test_debounce();
    test_reset_mid_press();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
